hi_ssp_tx: RTL and testbench

Buffered SSP transmit serializer for the HF reader path. It sits directly downstream of the HF reader correlator. It accepts one 16-bit report word (I byte in the upper byte, Q byte in the lower byte) per correlation window and serializes each word MSB-first to the ARM over ssp_clk, ssp_frame and ssp_din. A small FIFO decouples the correlator's report instant from the SSP bit grid. Words offered while the FIFO is full are dropped and flagged.

---
 rtl/hi_ssp_pkg.sv | 22 ++
 rtl/hi_ssp_tx_if.sv | 27 ++
 rtl/hi_ssp_fifo.sv | 75 +++++++
 rtl/hi_ssp_tx.sv | 130 +++++++++++++
 tb/tb_hi_ssp_tx.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/hi_ssp_pkg.sv
// Shared definitions for the HF reader SSP transmit path: FSM state
// encoding, SSP clock divider and the phase slots that place the SSP clock
// and frame edges inside one bit period.
package hi_ssp_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ssp_state_t;

    // One SSP bit spans SSP_DIV carrier clocks.
    localparam int SSP_DIV = 4;

    // Phase slots within a bit.
    // New bit / word load, and ssp_clk rises.
    localparam logic [1:0] P_LOAD      = 2'd0;
    localparam logic [1:0] P_CLK_SET   = 2'd0;
    localparam logic [1:0] P_CLK_CLR   = 2'd2;
    localparam logic [1:0] P_FRAME_SET = 2'd1;
    localparam logic [1:0] P_FRAME_CLR = 2'd3;

endpackage

// File: rtl/hi_ssp_tx_if.sv
// Report-word handshake between the HF reader correlator and the SSP
// transmitter.
//
// Handshake: the correlator drives word_in with word_valid high for the
// cycle it wants to offer a word; the transmitter drives a registered
// word_ready. A transfer happens on a clock edge where both are high. A
// word offered while word_ready is low is not held or retried: it is lost
// and the transmitter records an overrun.
interface hi_ssp_tx_if #(
    parameter int WORD_W = 16
);
    logic [WORD_W-1:0] word_in;
    logic              word_valid;
    logic              word_ready;

    modport master (
        output word_in,
        output word_valid,
        input  word_ready
    );

    modport slave (
        input  word_in,
        input  word_valid,
        output word_ready
    );
endinterface

// File: rtl/hi_ssp_fifo.sv
// Small synchronous FIFO between the correlator report instant and the SSP
// bit grid. Updates on the carrier negedge with a synchronous active-low
// reset that empties it. Full/empty come from the level count, so the
// pointers may simply wrap modulo DEPTH. push_ready is registered and
// reflects the level after this edge's push and pop.
module hi_ssp_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_valid,
    input  logic [W-1:0]             push_data,
    output logic                     push_ready,
    input  logic                     pop,
    output logic [W-1:0]             pop_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level_q;
    logic [LW-1:0] level_nx;
    logic          do_push;
    logic          do_pop;

    // A push needs the registered ready, so a full FIFO rejects the word
    // even when the same edge pops.
    assign do_push  = push_valid && push_ready;
    assign do_pop   = pop && (level_q != '0);
    assign empty    = (level_q == '0);
    assign level    = level_q;
    assign pop_data = mem[rd_ptr];

    // Occupancy after this edge's push and pop.
    always_comb begin
        level_nx = level_q;
        if (do_push && !do_pop) begin
            level_nx = level_q + 1'b1;
        end else if (!do_push && do_pop) begin
            level_nx = level_q - 1'b1;
        end
    end

    // Pointers, level and registered ready.
    always_ff @(negedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_q    <= '0;
            push_ready <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level_q    <= level_nx;
            push_ready <= (level_nx != LW'(DEPTH));
        end
    end

    // Storage write; contents need no reset since level gates every read.
    always_ff @(negedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/hi_ssp_tx.sv
// Buffered SSP transmit serializer for the HF reader path. Report words are
// queued in a small FIFO and shifted MSB-first to the ARM on ssp_din, one
// bit per four carrier clocks, with a free-running ssp_clk and a frame
// pulse in bit 0 of each word. Back-to-back words leave no gap bits.
//
// Optional feature: define HI_SSP_TX_OVERRUN_CNT_EN to add the saturating
// overrun_cnt port counting rejected pushes.
module hi_ssp_tx
    import hi_ssp_pkg::*;
#(
    parameter int WORD_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          ck_1356meg,
    input  logic                          rst_n,
    hi_ssp_tx_if.slave                    word_if,
    output logic                          ssp_clk,
    output logic                          ssp_frame,
    output logic                          ssp_din,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overrun,
`ifdef HI_SSP_TX_OVERRUN_CNT_EN
    output logic [7:0]                    overrun_cnt,
`endif
    output ssp_state_t                    state_dbg
);
    localparam int BW = $clog2(WORD_W);
    localparam int PW = $clog2(SSP_DIV);

    ssp_state_t        state_q;
    ssp_state_t        state_nx;
    logic [PW-1:0]     phase_q;
    logic [BW-1:0]     bit_q;
    logic [BW-1:0]     bit_nx;
    logic [WORD_W-1:0] shreg_q;
    logic [WORD_W-1:0] shreg_nx;
    logic              load_edge;
    logic              fifo_pop;
    logic              fifo_empty;
    logic [WORD_W-1:0] fifo_head;

    hi_ssp_fifo #(
        .W     (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (ck_1356meg),
        .rst_n      (rst_n),
        .push_valid (word_if.word_valid),
        .push_data  (word_if.word_in),
        .push_ready (word_if.word_ready),
        .pop        (fifo_pop),
        .pop_data   (fifo_head),
        .empty      (fifo_empty),
        .level      (fifo_level)
    );

    // Word boundary: start of a bit period while idle or after the last bit.
    assign load_edge = (phase_q == P_LOAD) &&
                       ((state_q == IDLE) || (bit_q == BW'(WORD_W - 1)));
    assign fifo_pop  = load_edge && !fifo_empty;
    assign ssp_din   = (state_q == SHIFT) && shreg_q[WORD_W-1];
    assign state_dbg = state_q;

    // Next-state: load a new word at the boundary, otherwise advance a bit.
    always_comb begin
        state_nx = state_q;
        bit_nx   = bit_q;
        shreg_nx = shreg_q;
        if (load_edge) begin
            if (!fifo_empty) begin
                shreg_nx = fifo_head;
                bit_nx   = '0;
                state_nx = SHIFT;
            end else begin
                state_nx = IDLE;
            end
        end else if ((state_q == SHIFT) && (phase_q == P_LOAD)) begin
            shreg_nx = {shreg_q[WORD_W-2:0], 1'b0};
            bit_nx   = bit_q + 1'b1;
        end
    end

    // State, shifter, phase counter and the registered SSP clock/frame pins.
    always_ff @(negedge ck_1356meg) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            phase_q   <= '0;
            bit_q     <= '0;
            shreg_q   <= '0;
            ssp_clk   <= 1'b0;
            ssp_frame <= 1'b0;
        end else begin
            state_q <= state_nx;
            phase_q <= phase_q + 1'b1;
            bit_q   <= bit_nx;
            shreg_q <= shreg_nx;
            if (phase_q == P_CLK_SET) begin
                ssp_clk <= 1'b1;
            end else if (phase_q == P_CLK_CLR) begin
                ssp_clk <= 1'b0;
            end
            if ((phase_q == P_FRAME_SET) && (state_q == SHIFT) && (bit_q == '0)) begin
                ssp_frame <= 1'b1;
            end else if (phase_q == P_FRAME_CLR) begin
                ssp_frame <= 1'b0;
            end
        end
    end

    // Sticky overrun flag: any word offered while not ready is lost.
    always_ff @(negedge ck_1356meg) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (word_if.word_valid && !word_if.word_ready) begin
            overrun <= 1'b1;
        end
    end

`ifdef HI_SSP_TX_OVERRUN_CNT_EN
    // Saturating count of rejected pushes.
    always_ff @(negedge ck_1356meg) begin
        if (!rst_n) begin
            overrun_cnt <= 8'd0;
        end else if (word_if.word_valid && !word_if.word_ready && (overrun_cnt != 8'hFF)) begin
            overrun_cnt <= overrun_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hi_ssp_tx.sv
// Self-checking bench for hi_ssp_tx. Directed pushes put their expected
// words into exp_q; a monitor rebuilds words from ssp_frame/ssp_clk/ssp_din
// and compares each against the queue head. The DUT updates on the carrier
// negedge, so the bench drives and samples around the posedge.
module tb_hi_ssp_tx;
    import hi_ssp_pkg::*;

    localparam int WORD_W     = 16;
    localparam int FIFO_DEPTH = 4;
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;

    // Clock and reset
    logic ck = 1'b0;
    logic rst_n = 1'b0;
    always #5 ck = ~ck;

    logic             ssp_clk;
    logic             ssp_frame;
    logic             ssp_din;
    logic [LVL_W-1:0] fifo_level;
    logic             overrun;
    ssp_state_t       state_dbg;
`ifdef HI_SSP_TX_OVERRUN_CNT_EN
    logic [7:0]       overrun_cnt;
`endif

    hi_ssp_tx_if #(.WORD_W(WORD_W)) word_if ();

    hi_ssp_tx #(
        .WORD_W     (WORD_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .ck_1356meg (ck),
        .rst_n      (rst_n),
        .word_if    (word_if),
        .ssp_clk    (ssp_clk),
        .ssp_frame  (ssp_frame),
        .ssp_din    (ssp_din),
        .fifo_level (fifo_level),
        .overrun    (overrun),
`ifdef HI_SSP_TX_OVERRUN_CNT_EN
        .overrun_cnt(overrun_cnt),
`endif
        .state_dbg  (state_dbg)
    );

    // Scoreboard state
    int                n_checks = 0;
    int                n_fail   = 0;
    int                cyc      = 0;
    logic [WORD_W-1:0] exp_q[$];
    int                frame_t[$];

    logic [WORD_W-1:0] burst_w [6] = '{16'h1111, 16'h2222, 16'h3333,
                                       16'h4444, 16'h5555, 16'h6666};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: rebuild serial words and compare with the expected queue
    logic              m_prev_clk   = 1'b0;
    logic              m_prev_frame = 1'b0;
    logic              m_in_word    = 1'b0;
    logic [WORD_W-1:0] m_sh         = '0;
    int                m_nbits      = 0;
    int                m_frame_len  = 0;

    initial begin
        forever begin
            @(posedge ck);
            #1;
            cyc++;
            if (!rst_n) begin
                m_in_word   = 1'b0;
                m_nbits     = 0;
                m_frame_len = 0;
                exp_q.delete();
            end else begin
                if (ssp_frame) m_frame_len++;
                if (ssp_frame && !m_prev_frame) begin
                    frame_t.push_back(cyc);
                    if (m_in_word) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL frame_mid_word: got frame after %0d bits, expected %0d", m_nbits, WORD_W);
                    end
                    m_in_word = 1'b1;
                    m_sh      = {{(WORD_W-1){1'b0}}, ssp_din};
                    m_nbits   = 1;
                end else if (ssp_clk && !m_prev_clk && m_in_word) begin
                    m_sh    = {m_sh[WORD_W-2:0], ssp_din};
                    m_nbits++;
                end
                if (!ssp_frame && m_prev_frame) begin
                    check("frame_width", m_frame_len, 2);
                    m_frame_len = 0;
                end
                if (m_in_word && (m_nbits == WORD_W)) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_word: got 0x%0h, expected no word", m_sh);
                    end else begin
                        check("word_data", m_sh, exp_q.pop_front());
                    end
                    m_in_word = 1'b0;
                end
            end
            m_prev_clk   = ssp_clk;
            m_prev_frame = ssp_frame;
        end
    end

    // Driver tasks
    // Return at the posedge just after a p==0 edge, so the next drive is
    // sampled on the p==1 edge.
    task automatic sync_p1();
        logic prev;
        prev = ssp_clk;
        for (int i = 0; i < 8; i++) begin
            @(posedge ck);
            if (ssp_clk && !prev) return;
            prev = ssp_clk;
        end
        n_checks++;
        n_fail++;
        $display("FAIL sync_timeout: got no ssp_clk rise in 8 cycles, expected one");
    endtask

    task automatic drive(input logic [WORD_W-1:0] w, input bit accept);
        word_if.word_in    = w;
        word_if.word_valid = 1'b1;
        if (accept) exp_q.push_back(w);
        @(posedge ck);
        word_if.word_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int limit);
        int i = 0;
        while ((exp_q.size() != 0) && (i < limit)) begin
            @(posedge ck);
            i++;
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ssp_clk"},    ssp_clk, 0);
        check({tag, "_ssp_frame"},  ssp_frame, 0);
        check({tag, "_ssp_din"},    ssp_din, 0);
        check({tag, "_word_ready"}, word_if.word_ready, 1);
        check({tag, "_fifo_level"}, fifo_level, 0);
        check({tag, "_overrun"},    overrun, 0);
        check({tag, "_state"},      state_dbg, IDLE);
`ifdef HI_SSP_TX_OVERRUN_CNT_EN
        check({tag, "_overrun_cnt"}, overrun_cnt, 0);
`endif
    endtask

    // Directed stimulus
    initial begin
        word_if.word_in    = '0;
        word_if.word_valid = 1'b0;
        rst_n              = 1'b0;
        repeat (3) @(posedge ck);
        check_reset_outputs("rst");

        // Idle after reset: ssp_clk 1,1,0,0 by phase, nothing else moves.
        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(posedge ck);
            check("idle_ssp_clk", ssp_clk, (((k - 1) % 4) < 2) ? 1 : 0);
            if ((k % 4) == 0) begin
                check("idle_frame", ssp_frame, 0);
                check("idle_din",   ssp_din, 0);
                check("idle_ready", word_if.word_ready, 1);
            end
        end

        // Single word 0xA55A from idle.
        frame_t.delete();
        sync_p1();
        drive(16'hA55A, 1'b1);
        wait_drain("drain_a55a", 100);
        repeat (8) @(posedge ck);
        check("a55a_frames", frame_t.size(), 1);
        check("a55a_din_after", ssp_din, 0);
        check("a55a_state_after", state_dbg, IDLE);

        // Two words 64 clocks apart form one contiguous 32-bit stream.
        frame_t.delete();
        sync_p1();
        drive(16'h0001, 1'b1);
        repeat (63) @(posedge ck);
        drive(16'h8000, 1'b1);
        wait_drain("drain_pair", 150);
        repeat (8) @(posedge ck);
        check("pair_frames", frame_t.size(), 2);
        if (frame_t.size() >= 2) check("pair_frame_gap", frame_t[1] - frame_t[0], 64);

        // Burst of 6 on consecutive clocks: 5 accepted, the 6th overruns.
        frame_t.delete();
        sync_p1();
        for (int i = 0; i < 6; i++) begin
            word_if.word_in    = burst_w[i];
            word_if.word_valid = 1'b1;
            if (i < 5) exp_q.push_back(burst_w[i]);
            @(posedge ck);
        end
        word_if.word_valid = 1'b0;
        check("burst_overrun", overrun, 1);
        check("burst_level", fifo_level, FIFO_DEPTH);
        check("burst_ready", word_if.word_ready, 0);
`ifdef HI_SSP_TX_OVERRUN_CNT_EN
        check("burst_overrun_cnt", overrun_cnt, 1);
`endif

        // Push while full on the edge that pops the second word.
        repeat (61) @(posedge ck);
        check("full_level_before", fifo_level, FIFO_DEPTH);
        check("full_ready_before", word_if.word_ready, 0);
        drive(16'hDEAD, 1'b0);
        check("full_level_after", fifo_level, FIFO_DEPTH - 1);
        check("full_ready_after", word_if.word_ready, 1);
        check("full_overrun", overrun, 1);
`ifdef HI_SSP_TX_OVERRUN_CNT_EN
        check("full_overrun_cnt", overrun_cnt, 2);
`endif
        wait_drain("drain_burst", 600);
        repeat (8) @(posedge ck);
        check("burst_frames", frame_t.size(), 5);

        // Reset for one clock during bit 7 of a word.
        sync_p1();
        drive(16'h1234, 1'b1);
        repeat (32) @(posedge ck);
        rst_n = 1'b0;
        @(posedge ck);
        check_reset_outputs("midrst");
        rst_n = 1'b1;
        frame_t.delete();
        repeat (4) @(posedge ck);
        sync_p1();
        drive(16'h5A3C, 1'b1);
        wait_drain("drain_after_rst", 100);
        repeat (8) @(posedge ck);
        check("after_rst_frames", frame_t.size(), 1);
        check("after_rst_din", ssp_din, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: got no end of test by cycle %0d, expected completion", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
